// File: rtl/tone_decoder.sv
// Measures the rise-to-rise period of a square-wave tone and reports a debounced C4..C5 note index.
// Outputs update the cycle after the synchronized rising edge; silence is declared after TIMEOUT clocks without an edge.
module tone_decoder #(
  parameter int CNT_W     = 20,
  parameter int TIMEOUT   = 500000,
  parameter int TOL_SHIFT = 6,
  parameter int P0        = 382226,
  parameter int P1        = 340530,
  parameter int P2        = 303370,
  parameter int P3        = 286344,
  parameter int P4        = 255102,
  parameter int P5        = 227273,
  parameter int P6        = 202478,
  parameter int P7        = 191113
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [2:0]       note,
  output logic             note_valid,
  output logic             silence
);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PTAB [8] = '{CNT_W'(P0), CNT_W'(P1), CNT_W'(P2), CNT_W'(P3),
                                            CNT_W'(P4), CNT_W'(P5), CNT_W'(P6), CNT_W'(P7)};

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic             meas, tmo;
  logic             cls_hit;
  logic [2:0]       cls_idx;
  logic             cand_vld;
  logic [2:0]       cand;

  // Distance is taken in whichever order is non-negative, so no wider arithmetic is needed.
  function automatic logic near(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] p);
    logic [CNT_W-1:0] d;
    d = (c >= p) ? (c - p) : (p - c);
    return d <= (p >> TOL_SHIFT);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tone_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Reloading with 1 makes the value seen on the next rise equal the exact edge spacing.
  always_ff @(posedge clk) begin
    if (reset)               cnt <= '0;
    else if (rise)           cnt <= CNT_W'(1);
    else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

  always_comb begin
    cls_hit = 1'b0;
    cls_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (near(cnt, PTAB[k])) begin
        cls_hit = 1'b1;
        cls_idx = 3'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    meas      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: if (rise) state_nxt = ARMED;
      ARMED: begin
        if (rise) begin
          state_nxt = MEASURE;
          meas      = 1'b1;
        end else if (cnt >= TMO) begin
          state_nxt = IDLE;
        end
      end
      MEASURE: begin
        if (rise) begin
          meas = 1'b1;
        end else if (cnt >= TMO) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period       <= '0;
      period_valid <= 1'b0;
      note         <= 3'd0;
      note_valid   <= 1'b0;
      silence      <= 1'b1;
      cand_vld     <= 1'b0;
      cand         <= 3'd0;
    end else begin
      period_valid <= meas;
      if (meas) begin
        period  <= cnt;
        silence <= 1'b0;
        if (cls_hit && cand_vld && (cls_idx == cand)) begin
          note       <= cand;
          note_valid <= 1'b1;
        end else begin
          cand_vld   <= cls_hit;
          cand       <= cls_idx;
          note_valid <= 1'b0;
        end
      end else if (tmo) begin
        period     <= '0;
        note_valid <= 1'b0;
        silence    <= 1'b1;
        cand_vld   <= 1'b0;
      end
    end
  end

endmodule
